// File: rtl/updi_rx_deserializer_if.sv
// Signal bundle between the raw UPDI line and the error handler.
// Line and enable go into the receiver; frame, valid, break and busy come out.
interface updi_rx_deserializer_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  rx_in;
   logic                  enable;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  valid_out;
   logic                  break_out;
   logic                  busy;

   modport master (
      output rx_in,
      output enable,
      input  data_out,
      input  valid_out,
      input  break_out,
      input  busy
   );

   modport slave (
      input  rx_in,
      input  enable,
      output data_out,
      output valid_out,
      output break_out,
      output busy
   );
endinterface

// File: rtl/updi_rx_deserializer.sv
// UPDI receive PHY: synchronizes the line, qualifies start bits at mid-bit and
// shifts each character LSB-first into a raw frame; all-zero frames flag a break.
module updi_rx_deserializer #(
   parameter int DATA_WIDTH   = 12,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   updi_rx_deserializer_if.slave  bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_WIDTH);

   localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]      HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]      BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]      IDX_ZERO   = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] FRAME_ZERO = {DATA_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t                state_r, state_s;
   logic [1:0]            sync_r;
   logic                  rx_s;
   logic                  armed_r, armed_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic [IDX_W-1:0]      idx_r, idx_s;
   logic [DATA_WIDTH-1:0] frame_r, frame_s;
   logic [DATA_WIDTH-1:0] data_r, data_s;
   logic                  valid_r, valid_s;
   logic                  break_r, break_s;
   logic                  busy_r, busy_s;

   assign rx_s = sync_r[1];

   // Next-state, bit sampling and output decode
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      frame_s = frame_r;
      data_s  = data_r;
      valid_s = 1'b0;
      break_s = 1'b0;
      armed_s = armed_r | rx_s;
      case (state_r)
         IDLE: begin
            cnt_s = CNT_ZERO;
            idx_s = IDX_ZERO;
            if (!rx_s && armed_r && bus.enable) begin
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (!bus.enable) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == HALF_LAST) begin
               cnt_s = CNT_ZERO;
               // A high line at mid start bit is a glitch, not a character
               if (rx_s) begin
                  state_s = IDLE;
               end else begin
                  frame_s[0] = 1'b0;
                  idx_s      = IDX_ONE;
                  state_s    = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         DATA: begin
            if (!bus.enable) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
               idx_s   = IDX_ZERO;
            end else if (cnt_r == BIT_LAST) begin
               cnt_s          = CNT_ZERO;
               frame_s[idx_r] = rx_s;
               idx_s          = idx_r + IDX_ONE;
               if (idx_r == IDX_LAST) begin
                  data_s  = frame_s;
                  valid_s = 1'b1;
                  break_s = (frame_s == FRAME_ZERO);
                  armed_s = 1'b0;
                  idx_s   = IDX_ZERO;
                  state_s = IDLE;
               end else begin
                  state_s = DATA;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
            idx_s   = IDX_ZERO;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State, synchronizer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         sync_r  <= 2'b11;
         armed_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
         idx_r   <= IDX_ZERO;
         frame_r <= FRAME_ZERO;
         data_r  <= FRAME_ZERO;
         valid_r <= 1'b0;
         break_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         sync_r  <= {sync_r[0], bus.rx_in};
         armed_r <= armed_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         frame_r <= frame_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         break_r <= break_s;
         busy_r  <= busy_s;
      end
   end

   assign bus.data_out  = data_r;
   assign bus.valid_out = valid_r;
   assign bus.break_out = break_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_updi_rx_deserializer.sv
// Directed bench for updi_rx_deserializer: table of serial characters plus
// hand-written glitch, break, back-to-back and abort sequences.
module tb_updi_rx_deserializer;
   localparam int DW  = 12;
   localparam int CPB = 16;
   localparam int LAT = (DW - 1) * CPB + CPB / 2 + 3;  // rx_in edge -> valid_out

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   logic [DW-1:0] q_data[$];
   logic          q_brk[$];
   int            q_cyc[$];
   int            n_break = 0;
   int            n_orphan = 0;

   updi_rx_deserializer_if #(.DATA_WIDTH(DW)) bus ();

   updi_rx_deserializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output pulse with the edge count it appeared after
   always @(negedge clk) begin
      if (bus.valid_out) begin
         q_data.push_back(bus.data_out);
         q_brk.push_back(bus.break_out);
         q_cyc.push_back(cyc);
      end
      if (bus.break_out) n_break = n_break + 1;
      if (bus.break_out && !bus.valid_out) n_orphan = n_orphan + 1;
   end

   typedef struct {
      string         name;
      logic [7:0]    data;
      logic          parity;
      logic [1:0]    stop;
      logic [DW-1:0] exp_data;
      logic          exp_brk;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_pulse(input string name, input int idx, input logic [DW-1:0] exp_data,
                            input logic exp_brk, input int exp_cyc);
      if (idx >= q_data.size()) begin
         n_chk  = n_chk + 1;
         n_fail = n_fail + 1;
         $display("FAIL %s: pulse %0d missing, got %0d pulses expected more", name, idx, q_data.size());
      end else begin
         chk({name, " data"}, 32'(q_data[idx]), 32'(exp_data));
         chk({name, " break"}, 32'(q_brk[idx]), 32'(exp_brk));
         chk({name, " cycle"}, 32'(q_cyc[idx]), 32'(exp_cyc));
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the line with a 12-bit pattern LSB first for ncyc cycles
   task automatic send_cycles(input logic [DW-1:0] bits, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         bus.rx_in = bits[c / CPB];
         tick(1);
      end
   endtask

   initial begin
      int base;
      int t0;
      logic [DW-1:0] bits;

      vecs[0] = '{"sync55",   8'h55, 1'b0, 2'b11, 12'hCAA, 1'b0};
      vecs[1] = '{"byte03",   8'h03, 1'b0, 2'b11, 12'hC06, 1'b0};
      vecs[2] = '{"byte00",   8'h00, 1'b0, 2'b11, 12'hC00, 1'b0};
      vecs[3] = '{"byteFF",   8'hFF, 1'b0, 2'b11, 12'hDFE, 1'b0};
      vecs[4] = '{"byte80",   8'h80, 1'b1, 2'b11, 12'hF00, 1'b0};
      vecs[5] = '{"byte01",   8'h01, 1'b1, 2'b11, 12'hE02, 1'b0};
      vecs[6] = '{"badstop",  8'h55, 1'b0, 2'b00, 12'h0AA, 1'b0};
      vecs[7] = '{"badstpar", 8'h55, 1'b1, 2'b00, 12'h2AA, 1'b0};

      reset      = 1'b1;
      bus.rx_in  = 1'b1;
      bus.enable = 1'b1;
      tick(3);
      chk("reset data_out", 32'(bus.data_out), 32'h0);
      chk("reset valid_out", 32'(bus.valid_out), 32'h0);
      chk("reset break_out", 32'(bus.break_out), 32'h0);
      chk("reset busy", 32'(bus.busy), 32'h0);
      reset = 1'b0;
      tick(5);

      for (int v = 0; v < 8; v++) begin
         bits = {vecs[v].stop, vecs[v].parity, vecs[v].data, 1'b0};
         base = q_data.size();
         t0   = cyc;
         send_cycles(bits, DW * CPB);
         bus.rx_in = 1'b1;
         tick(20);
         chk({vecs[v].name, " count"}, 32'(q_data.size() - base), 32'd1);
         chk_pulse(vecs[v].name, base, vecs[v].exp_data, vecs[v].exp_brk, t0 + LAT);
      end

      // Back-to-back frames with no idle gap
      base = q_data.size();
      t0   = cyc;
      send_cycles(12'hCAA, DW * CPB);
      send_cycles(12'hC06, DW * CPB);
      bus.rx_in = 1'b1;
      tick(20);
      chk("b2b count", 32'(q_data.size() - base), 32'd2);
      chk_pulse("b2b first", base, 12'hCAA, 1'b0, t0 + LAT);
      chk_pulse("b2b second", base + 1, 12'hC06, 1'b0, t0 + DW * CPB + LAT);

      // Short low glitch must be rejected at mid start bit
      base = q_data.size();
      bus.rx_in = 1'b0;
      tick(4);
      chk("glitch busy high", 32'(bus.busy), 32'h1);
      bus.rx_in = 1'b1;
      tick(40);
      chk("glitch busy low", 32'(bus.busy), 32'h0);
      chk("glitch count", 32'(q_data.size() - base), 32'd0);
      t0 = cyc;
      send_cycles(12'hCAA, DW * CPB);
      bus.rx_in = 1'b1;
      tick(20);
      chk_pulse("post glitch", base, 12'hCAA, 1'b0, t0 + LAT);

      // Line break: long low yields one all-zero frame, no retrigger
      base = q_data.size();
      t0   = cyc;
      bus.rx_in = 1'b0;
      tick(30 * CPB);
      bus.rx_in = 1'b1;
      tick(40);
      chk("break count", 32'(q_data.size() - base), 32'd1);
      chk_pulse("break", base, 12'h000, 1'b1, t0 + LAT);
      chk("break data held", 32'(bus.data_out), 32'h0);
      t0 = cyc;
      send_cycles(12'hCAA, DW * CPB);
      bus.rx_in = 1'b1;
      tick(20);
      chk_pulse("post break", base + 1, 12'hCAA, 1'b0, t0 + LAT);

      // Reset in the middle of bit 5
      base = q_data.size();
      send_cycles(12'hCAA, 5 * CPB + CPB / 2);
      chk("rst abort busy before", 32'(bus.busy), 32'h1);
      bus.rx_in = 1'b1;
      reset     = 1'b1;
      tick(1);
      chk("rst abort data_out", 32'(bus.data_out), 32'h0);
      chk("rst abort valid_out", 32'(bus.valid_out), 32'h0);
      chk("rst abort break_out", 32'(bus.break_out), 32'h0);
      chk("rst abort busy", 32'(bus.busy), 32'h0);
      reset = 1'b0;
      tick(250);
      chk("rst abort count", 32'(q_data.size() - base), 32'd0);

      // Enable dropped in the middle of bit 5
      send_cycles(12'hCAA, 5 * CPB + CPB / 2);
      chk("en abort busy before", 32'(bus.busy), 32'h1);
      bus.rx_in  = 1'b1;
      bus.enable = 1'b0;
      tick(1);
      chk("en abort data_out", 32'(bus.data_out), 32'h0);
      chk("en abort valid_out", 32'(bus.valid_out), 32'h0);
      chk("en abort busy", 32'(bus.busy), 32'h0);
      tick(250);
      chk("en abort count", 32'(q_data.size() - base), 32'd0);
      bus.enable = 1'b1;
      tick(5);
      t0 = cyc;
      send_cycles(12'hC06, DW * CPB);
      bus.rx_in = 1'b1;
      tick(20);
      chk_pulse("post abort", base, 12'hC06, 1'b0, t0 + LAT);

      chk("total break pulses", 32'(n_break), 32'd1);
      chk("break without valid", 32'(n_orphan), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
